// File: rtl/image_pixel_server.sv
// Pixel source/sink for the image-filter core: serves a host-loaded RGB image and captures filtered results.
// Optional session watchdog is compiled in when IMG_SRV_TIMEOUT_EN is defined.
module image_pixel_server #(
    parameter int ADDR_W = 8
`ifdef IMG_SRV_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [23:0]       ld_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    input  logic [1:0]        cfg_size,
    input  logic [1:0]        cfg_filter,
    input  logic              go,
    output logic              done,
    output logic              timeout,
    output logic              start,
    output logic [1:0]        size,
    output logic [1:0]        filter,
    output logic [23:0]       pixel_in,
    output logic              validData,
    input  logic [ADDR_W-1:0] Pixel_address,
    input  logic [7:0]        pixel_out,
    input  logic              ValidResult
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_r;
    logic [23:0]       image_ram [0:DEPTH-1];
    logic [7:0]        result_ram [0:DEPTH-1];
    logic [ADDR_W-1:0] addr_r;
    logic [CNT_W-1:0]  count_r;
    logic [CNT_W-1:0]  npix_s;
    logic              in_range_s;
    logic              go_accept_s;
    logic              result_we_s;
    logic              image_we_s;
    logic              last_result_s;
    logic              timeout_hit_s;

    // Session pixel count from the latched size code
    always_comb begin
        case (size)
            2'd0:    npix_s = CNT_W'(9'd16);
            2'd1:    npix_s = CNT_W'(9'd64);
            2'd2:    npix_s = CNT_W'(9'd256);
            default: npix_s = CNT_W'(9'd256);
        endcase
    end

    // Qualifiers for address range, session start and the two RAM write ports
    always_comb begin
        in_range_s    = ({1'b0, addr_r} < npix_s);
        go_accept_s   = go && ((state_r == ST_IDLE) || (state_r == ST_DONE));
        result_we_s   = !rst && (state_r == ST_RUN) && ValidResult;
        image_we_s    = !rst && ld_we && (state_r != ST_RUN);
        last_result_s = result_we_s && ((count_r + CNT_W'(1'b1)) == npix_s);
    end

    // Host image write port; contents survive reset
    always_ff @(posedge clk) begin
        if (image_we_s) begin
            image_ram[ld_addr] <= ld_data;
        end
    end

    // Result capture; count never reaches DEPTH inside RUN, so the low bits index safely
    always_ff @(posedge clk) begin
        if (result_we_s) begin
            result_ram[count_r[ADDR_W-1:0]] <= pixel_out;
        end
    end

    // Registered host read of the result buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= 8'h00;
        end else begin
            rd_data <= result_ram[rd_addr];
        end
    end

    // Session FSM with registered core-facing outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            start     <= 1'b0;
            validData <= 1'b0;
            done      <= 1'b0;
            size      <= 2'd0;
            filter    <= 2'd0;
            pixel_in  <= 24'h000000;
            count_r   <= '0;
            addr_r    <= '0;
        end else begin
            addr_r <= Pixel_address;
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (go_accept_s) begin
                        state_r   <= ST_RUN;
                        size      <= cfg_size;
                        filter    <= cfg_filter;
                        count_r   <= '0;
                        start     <= 1'b1;
                        validData <= 1'b0;
                        done      <= 1'b0;
                    end
                end
                ST_RUN: begin
                    pixel_in <= in_range_s ? image_ram[addr_r] : 24'h000000;
                    if (result_we_s) begin
                        count_r <= count_r + CNT_W'(1'b1);
                    end
                    if (last_result_s || timeout_hit_s) begin
                        state_r   <= ST_DONE;
                        start     <= 1'b0;
                        validData <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        validData <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    start     <= 1'b0;
                    validData <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

`ifdef IMG_SRV_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [IDLE_W-1:0] idle_r;
    logic              timeout_r;

    assign timeout_hit_s = (state_r == ST_RUN) && !ValidResult &&
                           (idle_r == IDLE_W'(TIMEOUT_CYCLES - 1));
    assign timeout       = timeout_r;

    // Watchdog: counts RUN cycles without a result, cleared by go and by each result
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_r    <= '0;
            timeout_r <= 1'b0;
        end else if (go_accept_s) begin
            idle_r    <= '0;
            timeout_r <= 1'b0;
        end else if (state_r == ST_RUN) begin
            if (ValidResult) begin
                idle_r <= '0;
            end else if (timeout_hit_s) begin
                idle_r    <= '0;
                timeout_r <= 1'b1;
            end else begin
                idle_r <= idle_r + IDLE_W'(1'b1);
            end
        end else begin
            idle_r <= idle_r;
        end
    end
`else
    assign timeout_hit_s = 1'b0;
    assign timeout       = 1'b0;
`endif

endmodule
